reduce_gate_pipe: RTL and testbench
===================================

// Module: reduce_gate_pipe
// PURPOSE
//  Parametrised successor to the fixed 3-input OR cell. Computes a WIDTH-input
//  reduction gate (OR/NOR/AND/NAND/XOR/XNOR) over a streamed input word.
//  The result comes out through a LATENCY-stage register pipeline.
//  A valid/ready handshake on both sides carries back-pressure.
//  It sits between a stimulus source and a result sink in the ModelSim
//  gate-level education benches.
// PARAMETERS
//  WIDTH    8     number of gate inputs; legal range 2..32
//  FUNC     "or"  reduction function: "or","nor","and","nand","xor","xnor"
//  LATENCY  2     pipeline register stages; legal range 1..4
//  CNT_W    16    width of the result-ones counter (macro build only)
// PORTS
//  clk       in   1       rising-edge clock
//  rst_n     in   1       asynchronous reset, active low
//  x_valid   in   1       input word present
//  x_ready   out  1       block can take the word this cycle
//  x         in   WIDTH   gate inputs
//  y_valid   out  1       result present
//  y_ready   in   1       sink takes the result this cycle
//  y         out  1       gate result
//  clr_cnt   in   1       synchronous counter clear (REDUCE_GATE_CNT_EN only)
//  ones_cnt  out  CNT_W   count of accepted results equal to 1 (REDUCE_GATE_CNT_EN only)
// BEHAVIOUR
//  - Reset (rst_n=0, asynchronous):
//    - all stage valid bits are 0; y_valid=0, y=0, ones_cnt=0.
//    - x_ready is 1 as soon as reset is applied.
//    - A reset mid-stream drops all in-flight words; no output follows them.
//  - Stages s[0..LATENCY-1], each holding {v, d}:
//    - s[0] captures the reduction of x.
//    - Every later stage copies the stage before it; y_valid = v of the last stage.
//  - Advance rule (combinational chain, no bubbles):
//    - adv[LATENCY-1] = !v[LATENCY-1] | y_ready
//    - adv[i] = !v[i] | adv[i+1]
//    - x_ready = adv[0]
//    - x_ready may depend combinationally on y_ready. This is allowed.
//  - Transfers:
//    - The input is accepted when x_valid & x_ready.
//    - The output is accepted when y_valid & y_ready.
//    - If a stage advances and its source is empty, it loads v=0.
//  - Latency and throughput:
//    - Latency is exactly LATENCY cycles, from the accept edge to y_valid, when there is no stall.
//    - Throughput is 1 word per cycle while y_ready stays 1.
//  - Stall: while y_valid & !y_ready, y and every stage stay frozen.
//    No word is lost and no word is duplicated.
//  - Accept and release in the same cycle on a full pipeline is allowed; the pipeline shifts by one.
//  - Function definitions:
//    - or = |x, and = &x, xor = ^x
//    - the n-variants are the inverses of these
//    - the reduction uses the full WIDTH; no truncation
//  - X on x while x_valid=0 must not propagate: d is loaded only on an input accept.
//  - Illegal parameters:
//    - An unknown FUNC string or an out-of-range WIDTH/LATENCY triggers $error at elaboration.
//    - In that case y is tied to 0.
// CONFIGURATION
//  - `REDUCE_GATE_CNT_EN defined:
//    - ones_cnt increments on each output accept where y=1.
//    - It saturates at 2^CNT_W-1 and does not wrap.
//    - clr_cnt=1 forces 0 on the next edge. If clr_cnt and an increment occur in the same cycle, the clear wins.
//  - `REDUCE_GATE_CNT_EN undefined: clr_cnt and ones_cnt are absent from the port list and the counter logic is not built.
// TESTING
//  - Reset:
//    - drive rst_n=0 mid-stream, with 2 words in flight and LATENCY=2
//    - required: y_valid=0 and x_ready=1 immediately (asynchronous), ones_cnt=0
//    - required: no stale output after release
//  - Function sweep, WIDTH=3, FUNC="or", all 8 codes of x, y_ready=1:
//    - required: y=0 only for x=3'b000
//    - required: each result appears 2 cycles after its accept
//    - Repeat for "and": y=1 only for x=3'b111.
//    - Repeat for "xor": x=3'b101 gives y=0 and x=3'b111 gives y=1.
//  - Back-pressure:
//    - stream 6 words with y_ready=0 for cycles 3..7
//    - required: x_ready falls once LATENCY words are held
//    - required: y stays stable while stalled
//    - required: all 6 results arrive in order, none lost or duplicated
//  - Full throughput, WIDTH=32, FUNC="nand", 100 back-to-back words:
//    - use x=32'hFFFFFFFF on every 4th word
//    - required: 100 outputs in 100+LATENCY cycles
//    - required: y=0 exactly on those words
//  - Counter (macro on, CNT_W=4):
//    - 20 accepted results with y=1 -> ones_cnt saturates at 15
//    - clr_cnt together with an increment -> ones_cnt=0

Source files
------------

// File: rtl/reduce_gate_pipe.sv
// WIDTH-input reduction gate (FUNC: or/nor/and/nand/xor/xnor) behind a LATENCY-stage valid/ready pipeline.
// Latency LATENCY cycles with no bubbles; a stalled sink freezes every stage and x_ready follows y_ready combinationally.
// Optional saturating ones counter when REDUCE_GATE_CNT_EN is defined.
module reduce_gate_pipe #(
  parameter int    WIDTH   = 8,
  parameter string FUNC    = "or",
  parameter int    LATENCY = 2,
  parameter int    CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             x_valid,
  output logic             x_ready,
  input  logic [WIDTH-1:0] x,
  output logic             y_valid,
  input  logic             y_ready,
  output logic             y
`ifdef REDUCE_GATE_CNT_EN
  ,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] ones_cnt
`endif
);

  localparam int FSEL = (FUNC == "or")   ? 0 :
                        (FUNC == "nor")  ? 1 :
                        (FUNC == "and")  ? 2 :
                        (FUNC == "nand") ? 3 :
                        (FUNC == "xor")  ? 4 :
                        (FUNC == "xnor") ? 5 : -1;

  localparam bit LEGAL = (FSEL >= 0) && (WIDTH >= 2) && (WIDTH <= 32) &&
                         (LATENCY >= 1) && (LATENCY <= 4) && (CNT_W >= 1);

  // Keep the stage vector sized sanely even when LATENCY is out of range.
  localparam int LS = (LATENCY < 1) ? 1 : LATENCY;

  if (!LEGAL) begin : g_bad_params
    $error("reduce_gate_pipe: illegal FUNC/WIDTH/LATENCY/CNT_W");
  end

  logic          red;
  logic [LS-1:0] v_q, v_d;
  logic [LS-1:0] d_q, d_d;
  logic [LS-1:0] adv;
  logic          adv_acc;

  always_comb begin
    red = 1'b0;
    case (FSEL)
      0:       red = |x;
      1:       red = ~|x;
      2:       red = &x;
      3:       red = ~&x;
      4:       red = ^x;
      5:       red = ~^x;
      default: red = 1'b0;
    endcase
  end

  // A stage may move when it is empty or anything downstream of it moves.
  always_comb begin
    adv     = '0;
    adv_acc = y_ready;
    for (int i = LS - 1; i >= 0; i--) begin
      adv_acc = adv_acc | ~v_q[i];
      adv[i]  = adv_acc;
    end
  end

  always_comb begin
    v_d = v_q;
    d_d = d_q;
    if (adv[0]) begin
      v_d[0] = x_valid;
      if (x_valid) begin
        d_d[0] = red;
      end
    end
    for (int i = 1; i < LS; i++) begin
      if (adv[i]) begin
        v_d[i] = v_q[i-1];
        if (v_q[i-1]) begin
          d_d[i] = d_q[i-1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      d_q <= '0;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
    end
  end

  assign x_ready = adv[0];
  assign y_valid = v_q[LS-1];
  assign y       = LEGAL ? d_q[LS-1] : 1'b0;

`ifdef REDUCE_GATE_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt) begin
      cnt_d = '0;
    end else if (y_valid && y_ready && y && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign ones_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_reduce_gate_pipe.sv
// Scoreboard bench: four reduce_gate_pipe instances share one handshake; expected bits queued on accept.
module tb_reduce_gate_pipe;

  localparam int LAT = 2;
  localparam int NI  = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        x_valid;
  logic        y_ready;
  logic [31:0] x;
  logic        xr [NI];
  logic        yv [NI];
  logic        yo [NI];
`ifdef REDUCE_GATE_CNT_EN
  logic        clr_cnt;
  logic [3:0]  ones [NI];
`endif

  always #5 clk = ~clk;

  reduce_gate_pipe #(.WIDTH(3), .FUNC("or"), .LATENCY(LAT), .CNT_W(4)) u_or (
    .clk(clk), .rst_n(rst_n), .x_valid(x_valid), .x_ready(xr[0]), .x(x[2:0]),
    .y_valid(yv[0]), .y_ready(y_ready), .y(yo[0])
`ifdef REDUCE_GATE_CNT_EN
    , .clr_cnt(clr_cnt), .ones_cnt(ones[0])
`endif
  );
  reduce_gate_pipe #(.WIDTH(3), .FUNC("and"), .LATENCY(LAT), .CNT_W(4)) u_and (
    .clk(clk), .rst_n(rst_n), .x_valid(x_valid), .x_ready(xr[1]), .x(x[2:0]),
    .y_valid(yv[1]), .y_ready(y_ready), .y(yo[1])
`ifdef REDUCE_GATE_CNT_EN
    , .clr_cnt(clr_cnt), .ones_cnt(ones[1])
`endif
  );
  reduce_gate_pipe #(.WIDTH(3), .FUNC("xor"), .LATENCY(LAT), .CNT_W(4)) u_xor (
    .clk(clk), .rst_n(rst_n), .x_valid(x_valid), .x_ready(xr[2]), .x(x[2:0]),
    .y_valid(yv[2]), .y_ready(y_ready), .y(yo[2])
`ifdef REDUCE_GATE_CNT_EN
    , .clr_cnt(clr_cnt), .ones_cnt(ones[2])
`endif
  );
  reduce_gate_pipe #(.WIDTH(32), .FUNC("nand"), .LATENCY(LAT), .CNT_W(4)) u_nand (
    .clk(clk), .rst_n(rst_n), .x_valid(x_valid), .x_ready(xr[3]), .x(x),
    .y_valid(yv[3]), .y_ready(y_ready), .y(yo[3])
`ifdef REDUCE_GATE_CNT_EN
    , .clr_cnt(clr_cnt), .ones_cnt(ones[3])
`endif
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int st_lo    = 1;
  int st_hi    = 0;
  bit lat_chk  = 1'b0;
  bit xr_fell  = 1'b0;
  int out_cnt [NI];

  logic exp_q   [NI][$];
  int   stamp_q [NI][$];
  bit   was_stall [NI];
  logic hold_y    [NI];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
    y_ready = !((cyc >= st_lo) && (cyc <= st_hi));
  endtask

  task automatic send(input logic [31:0] val);
    bit done;
    done    = 1'b0;
    x_valid = 1'b1;
    x       = val;
    for (int k = 0; k < 100 && !done; k++) begin
      @(negedge clk);
      if (x_ready_any()) done = 1'b1;
      step();
    end
    if (!done) chk("send_timeout", 32'd0, 32'd1);
    x_valid = 1'b0;
  endtask

  function automatic bit x_ready_any();
    return xr[0];
  endfunction

  task automatic drain();
    bit empty;
    empty = 1'b0;
    for (int k = 0; k < 60 && !empty; k++) begin
      empty = 1'b1;
      for (int j = 0; j < NI; j++) if (exp_q[j].size() != 0) empty = 1'b0;
      if (!empty) step();
    end
    if (!empty) chk("drain_timeout", 32'd0, 32'd1);
  endtask

  // Monitor: sampled on the falling edge, pre-edge values for the next rising edge.
  always @(negedge clk) begin
    logic e;
    int   st;
    if (!rst_n) begin
      for (int j = 0; j < NI; j++) was_stall[j] = 1'b0;
    end else begin
      for (int j = 0; j < NI; j++) begin
        chk($sformatf("x_ready%0d", j), xr[j], ((exp_q[j].size() < LAT) || y_ready) ? 1 : 0);
        if (!xr[j]) xr_fell = 1'b1;
        if (yv[j] && !y_ready) begin
          if (was_stall[j]) chk($sformatf("hold%0d", j), yo[j], hold_y[j]);
          was_stall[j] = 1'b1;
          hold_y[j]    = yo[j];
        end else begin
          was_stall[j] = 1'b0;
        end
        if (yv[j] && y_ready) begin
          if (exp_q[j].size() == 0) begin
            chk($sformatf("stale_out%0d", j), 32'd1, 32'd0);
          end else begin
            e  = exp_q[j].pop_front();
            st = stamp_q[j].pop_front();
            chk($sformatf("y%0d", j), yo[j], e);
            if (lat_chk) chk($sformatf("lat%0d", j), cyc - st, LAT);
            out_cnt[j]++;
          end
        end
      end
      if (x_valid && xr[0]) begin
        exp_q[0].push_back(|x[2:0]);
        exp_q[1].push_back(&x[2:0]);
        exp_q[2].push_back(^x[2:0]);
        exp_q[3].push_back(~&x);
        for (int j = 0; j < NI; j++) stamp_q[j].push_back(cyc);
      end
    end
  end

  initial begin
    logic [31:0] bp_words [6];
    logic [31:0] w;
    int t0;
    bp_words = '{32'h0, 32'h5, 32'h3, 32'h7, 32'h1, 32'h6};
    rst_n   = 1'b0;
    x_valid = 1'b0;
    x       = '0;
    y_ready = 1'b1;
`ifdef REDUCE_GATE_CNT_EN
    clr_cnt = 1'b0;
`endif
    #1;
    for (int j = 0; j < NI; j++) begin
      chk($sformatf("rst_yvld%0d", j), yv[j], 0);
      chk($sformatf("rst_y%0d", j), yo[j], 0);
      chk($sformatf("rst_xrdy%0d", j), xr[j], 1);
    end
    step(); step();
    rst_n = 1'b1;
    step();

    // Exhaustive 3-bit sweep with a free-running sink; latency checked too.
    lat_chk = 1'b1;
    for (int i = 0; i < 8; i++) send(32'(i));
    drain();
    lat_chk = 1'b0;

    // Back-pressure window partway through a 6-word stream.
    xr_fell = 1'b0;
    st_lo = cyc + 3;
    st_hi = cyc + 7;
    for (int i = 0; i < 6; i++) send(bp_words[i]);
    drain();
    st_lo = 1;
    st_hi = 0;
    step();
    chk("bp_xready_fell", xr_fell, 1);

    // Back-to-back 32-bit stream; every 4th word all ones.
    for (int j = 0; j < NI; j++) out_cnt[j] = 0;
    t0 = cyc;
    for (int i = 0; i < 100; i++) begin
      w = $urandom();
      if (i % 4 == 0) w = 32'hFFFF_FFFF;
      else            w[$urandom_range(31, 0)] = 1'b0;
      send(w);
    end
    drain();
    chk("tput_outputs", out_cnt[3], 100);
    chk("tput_cycles", cyc - t0, 100 + LAT);

    // Asynchronous reset with two words in flight.
    send(32'h1);
    send(32'h2);
    chk("pre_rst_yvld", yv[0], 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_yvld", yv[0], 0);
    chk("mid_rst_xrdy", xr[0], 1);
`ifdef REDUCE_GATE_CNT_EN
    chk("mid_rst_cnt", ones[0], 0);
`endif
    for (int j = 0; j < NI; j++) begin
      exp_q[j].delete();
      stamp_q[j].delete();
    end
    step(); step();
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("post_rst_no_out", yv[0], 0);
    end

`ifdef REDUCE_GATE_CNT_EN
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    chk("cnt_clr", ones[0], 0);
    for (int i = 0; i < 20; i++) send(32'h1);
    drain();
    step();
    chk("cnt_sat", ones[0], 15);
    clr_cnt = 1'b1;
    for (int i = 0; i < 3; i++) send(32'h1);
    drain();
    step();
    clr_cnt = 1'b0;
    chk("cnt_clr_wins", ones[0], 0);
    send(32'h1);
    drain();
    step();
    chk("cnt_after_clr", ones[0], 1);
`endif

    for (int j = 0; j < NI; j++) chk($sformatf("sb_empty%0d", j), exp_q[j].size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
